// File: rtl/lab02_reg_exec.sv
`default_nettype none
// ============================================================================
// Module      : lab02_reg_exec
// Description : 32 x 32-bit register file with a three-state execute
//               sequencer (IDLE -> EXEC -> WB) feeding lab02_alu. Operands
//               and opcode are presented to the ALU from registers, the ALU
//               result is captured and written back, and every write-back
//               is reported on the wb_* status port.
// Ports       : clk, rst (async, active high)
//               cmd_valid/cmd_ready, cmd_op/cmd_rs/cmd_rt/cmd_rd : command
//               alu_a, alu_b, alu_op (out), alu_out, sign (in)  : ALU link
//               wb_valid, wb_rd, wb_data, wb_sign               : write-back
//               init_we, init_addr, init_data                   : preload
//               dbg_addr -> dbg_data (combinational)            : debug read
//               busy                                            : EXEC or WB
// Revision    : 1.0 - initial release
// ============================================================================
module lab02_reg_exec #(
  parameter int NREG   = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [4:0]        cmd_op,
  input  logic [4:0]        cmd_rs,
  input  logic [4:0]        cmd_rt,
  input  logic [4:0]        cmd_rd,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [4:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              sign,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_sign,
  input  logic              init_we,
  input  logic [4:0]        init_addr,
  input  logic [DATA_W-1:0] init_data,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              busy
);

  localparam logic [4:0] OP_NOP = 5'h00;
  localparam logic [4:0] OP_ADD = 5'h01;
  localparam logic [4:0] OP_SUB = 5'h02;
  localparam logic [4:0] OP_MAX = 5'h06;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] regs [NREG];
  logic [4:0]        op_q;        // effective opcode of the command in flight
  logic [4:0]        rd_q;        // destination of the command in flight
  logic [4:0]        cmd_op_eff;  // undefined opcodes collapse to NOP
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic              accept;

  assign cmd_ready  = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign accept     = (state == ST_IDLE) && cmd_valid;
  assign cmd_op_eff = (cmd_op <= OP_MAX) ? cmd_op : OP_NOP;

  // r0 is forced to read zero on every read path.
  assign rs_val   = (cmd_rs   == 5'd0) ? '0 : regs[cmd_rs];
  assign rt_val   = (cmd_rt   == 5'd0) ? '0 : regs[cmd_rt];
  assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (cmd_valid) state_next = ST_EXEC;
      ST_EXEC: state_next = ST_WB;
      ST_WB:   state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Register file. Init writes only land in IDLE and write-back only in WB,
  // so the two write sources can never collide. Operands are read
  // combinationally from the pre-edge contents, so an init write in the
  // accept cycle is not bypassed into the operands.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if ((state == ST_IDLE) && init_we && (init_addr != 5'd0)) begin
      regs[init_addr] <= init_data;
    end else if ((state == ST_WB) && (op_q != OP_NOP) && (wb_rd != 5'd0)) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // --------------------------------------------------------------------------
  // ALU operand launch and result capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= OP_NOP;
      op_q     <= OP_NOP;
      rd_q     <= 5'd0;
      wb_valid <= 1'b0;
      wb_rd    <= 5'd0;
      wb_data  <= '0;
      wb_sign  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            alu_a  <= rs_val;
            alu_b  <= rt_val;
            alu_op <= cmd_op_eff;
            op_q   <= cmd_op_eff;
            rd_q   <= cmd_rd;
          end
        end
        ST_EXEC: begin
          wb_data  <= alu_out;
          wb_rd    <= rd_q;
          // Carry/borrow only has meaning for the arithmetic ops.
          wb_sign  <= ((op_q == OP_ADD) || (op_q == OP_SUB)) ? sign : 1'b0;
          wb_valid <= (op_q != OP_NOP);
          alu_op   <= OP_NOP;
        end
        ST_WB: begin
          wb_valid <= 1'b0;
        end
        default: begin
          wb_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lab02_reg_exec.sv
`default_nettype none
// ============================================================================
// Module      : tb_lab02_reg_exec
// Description : Self-checking bench for lab02_reg_exec. Contains a stand-in
//               ALU and a register-file reference model built from the
//               command semantics (array of 32 words plus arithmetic).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lab02_reg_exec;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [4:0]  cmd_op, cmd_rs, cmd_rt, cmd_rd;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [4:0]  alu_op;
  logic        sign;
  logic        wb_valid, wb_sign;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        init_we;
  logic [4:0]  init_addr;
  logic [31:0] init_data;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] model [32];

  // observations from the last command
  logic        o_rdy0, o_busy_e, o_wbv_e, o_rdy_e, o_wbv_w, o_rdy_w, o_busy_w;
  logic        o_wbv_i, o_rdy_i, o_busy_i, o_sign_w;
  logic [4:0]  o_op_e, o_rd_w;
  logic [31:0] o_a_e, o_b_e, o_data_w, o_dbg;
  // expectations for the last command
  logic [4:0]  x_op;
  logic [31:0] x_a, x_b, x_data;
  logic        x_valid, x_sign;

  always #5 clk = ~clk;

  lab02_reg_exec #(.NREG(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .sign(sign),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_sign(wb_sign),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy(busy)
  );

  // What a command computes: {carry/borrow, result}; logic ops carry 0.
  function automatic logic [32:0] spec_exec(input logic [4:0] op,
                                            input logic [31:0] a, b);
    logic [32:0] w;
    case (op)
      5'd1: w = {1'b0, a} + {1'b0, b};
      5'd2: w = {1'b0, a} - {1'b0, b};
      5'd3: w = {1'b0, a & b};
      5'd4: w = {1'b0, a | b};
      5'd5: w = {1'b0, a ^ b};
      5'd6: w = {1'b0, ~(a | b)};
      default: w = 33'd0;
    endcase
    return w;
  endfunction

  // Stand-in ALU; for logic ops bit 32 carries junk (parity) so that the
  // sequencer has to mask it.
  function automatic logic [32:0] alu_stub(input logic [4:0] op,
                                           input logic [31:0] a, b);
    logic [32:0] w;
    w = spec_exec(op, a, b);
    if (op >= 5'd3 && op <= 5'd6) w[32] = ^w[31:0];
    return w;
  endfunction

  always_comb {sign, alu_out} = alu_stub(alu_op, alu_a, alu_b);

  task automatic idle_inputs();
    cmd_valid = 0; cmd_op = 0; cmd_rs = 0; cmd_rt = 0; cmd_rd = 0;
    init_we = 0; init_addr = 0; init_data = 0; dbg_addr = 0;
  endtask

  task automatic init_write(input logic [4:0] a, input logic [31:0] d);
    init_we = 1; init_addr = a; init_data = d;
    @(posedge clk); @(negedge clk);
    init_we = 0;
    if (a != 0) model[a] = d;
  endtask

  // Called at a negedge while IDLE; returns at the next IDLE negedge (+1).
  task automatic run_cmd(input logic [4:0] op, rd, rs, rt, input bit hold,
                         input bit init_en, input logic [4:0] ia,
                         input logic [31:0] id, input bit exec_init);
    logic [32:0] r;
    x_op    = (op > 5'd6) ? 5'd0 : op;
    x_a     = (rs == 0) ? 32'd0 : model[rs];
    x_b     = (rt == 0) ? 32'd0 : model[rt];
    r       = spec_exec(x_op, x_a, x_b);
    x_data  = r[31:0];
    x_sign  = r[32];
    x_valid = (x_op != 0);
    o_rdy0  = cmd_ready;
    cmd_valid = 1; cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_rt = rt;
    init_we = init_en; init_addr = ia; init_data = id;
    @(posedge clk); @(negedge clk);
    if (init_en && ia != 0) model[ia] = id;
    o_busy_e = busy; o_op_e = alu_op; o_a_e = alu_a; o_b_e = alu_b;
    o_wbv_e = wb_valid; o_rdy_e = cmd_ready;
    init_we = exec_init; init_addr = 5'($urandom_range(1, 31)); init_data = $urandom;
    if (hold) begin
      cmd_op = 5'($urandom); cmd_rd = 5'($urandom); cmd_rs = 5'($urandom); cmd_rt = 5'($urandom);
    end else cmd_valid = 0;
    @(negedge clk);
    o_wbv_w = wb_valid; o_rd_w = wb_rd; o_data_w = wb_data; o_sign_w = wb_sign;
    o_rdy_w = cmd_ready; o_busy_w = busy;
    if (hold) begin
      cmd_op = 5'($urandom); cmd_rd = 5'($urandom); cmd_rs = 5'($urandom); cmd_rt = 5'($urandom);
    end
    @(negedge clk);
    cmd_valid = 0; init_we = 0;
    o_wbv_i = wb_valid; o_rdy_i = cmd_ready; o_busy_i = busy;
    if (x_valid && rd != 0) model[rd] = x_data;
    dbg_addr = rd; #1; o_dbg = dbg_data;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    @(negedge clk); @(negedge clk);
    rst = 0;
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
    n_cmp++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wbv: got %b expected 0", wb_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if ({alu_op, alu_a, alu_b} !== 69'd0) begin n_fail++; $display("FAIL reset_alu: got op %h a %h b %h expected zeros", alu_op, alu_a, alu_b); end
    n_cmp++; if ({wb_rd, wb_data, wb_sign} !== 38'd0) begin n_fail++; $display("FAIL reset_wb: got rd %h data %h sign %b expected zeros", wb_rd, wb_data, wb_sign); end
    for (int i = 0; i < 32; i++) begin
      dbg_addr = i[4:0]; #1;
      n_cmp++; if (dbg_data !== 32'd0) begin n_fail++; $display("FAIL reset_reg%0d: got %h expected 0", i, dbg_data); end
    end
    @(negedge clk);
  endtask

  task automatic test_add_overflow();
    init_write(5'd1, 32'h7FFF_FFFF);
    init_write(5'd2, 32'h0000_0001);
    run_cmd(5'd1, 5'd3, 5'd1, 5'd2, 0, 0, 5'd0, 32'd0, 0);
    n_cmp++; if (o_rdy0 !== 1'b1 || o_busy_e !== 1'b1 || o_rdy_e !== 1'b0) begin n_fail++; $display("FAIL add_handshake: got rdy %b busy %b rdy_exec %b expected 1 1 0", o_rdy0, o_busy_e, o_rdy_e); end
    n_cmp++; if ({o_wbv_e, o_wbv_w, o_wbv_i} !== 3'b010) begin n_fail++; $display("FAIL add_wbv_timing: got %b expected 010", {o_wbv_e, o_wbv_w, o_wbv_i}); end
    n_cmp++; if (o_data_w !== 32'h8000_0000 || o_sign_w !== 1'b0 || o_rd_w !== 5'd3) begin n_fail++; $display("FAIL add_wb: got data %h sign %b rd %0d expected 80000000 0 3", o_data_w, o_sign_w, o_rd_w); end
    n_cmp++; if (o_rdy_w !== 1'b0 || o_busy_w !== 1'b1 || o_rdy_i !== 1'b1 || o_busy_i !== 1'b0) begin n_fail++; $display("FAIL add_busy: got wb rdy %b busy %b, idle rdy %b busy %b expected 0 1 1 0", o_rdy_w, o_busy_w, o_rdy_i, o_busy_i); end
    n_cmp++; if (o_dbg !== 32'h8000_0000) begin n_fail++; $display("FAIL add_r3: got %h expected 80000000", o_dbg); end
  endtask

  task automatic test_back_to_back();
    init_write(5'd4, 32'd0);
    init_write(5'd5, 32'd1);
    run_cmd(5'd2, 5'd6, 5'd4, 5'd5, 0, 0, 5'd0, 32'd0, 0);
    n_cmp++; if (o_data_w !== 32'hFFFF_FFFF || o_sign_w !== 1'b1 || o_wbv_w !== 1'b1) begin n_fail++; $display("FAIL sub_wb: got data %h sign %b valid %b expected ffffffff 1 1", o_data_w, o_sign_w, o_wbv_w); end
    run_cmd(5'd5, 5'd7, 5'd6, 5'd5, 0, 0, 5'd0, 32'd0, 0);
    n_cmp++; if (o_rdy0 !== 1'b1 || o_a_e !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL b2b_operand: got rdy %b a %h expected 1 ffffffff", o_rdy0, o_a_e); end
    n_cmp++; if (o_data_w !== 32'hFFFF_FFFE || o_sign_w !== 1'b0 || o_dbg !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL b2b_xor: got data %h sign %b r7 %h expected fffffffe 0 fffffffe", o_data_w, o_sign_w, o_dbg); end
  endtask

  task automatic test_write_protect();
    init_write(5'd9, 32'hF0F0_F0F0);
    init_write(5'd10, 32'hFF00_FF00);
    run_cmd(5'd3, 5'd0, 5'd9, 5'd10, 0, 0, 5'd0, 32'd0, 0);
    n_cmp++; if (o_wbv_w !== 1'b1 || o_rd_w !== 5'd0 || o_data_w !== 32'hF000_F000 || o_sign_w !== 1'b0) begin n_fail++; $display("FAIL and_r0_wb: got valid %b rd %0d data %h sign %b expected 1 0 f000f000 0", o_wbv_w, o_rd_w, o_data_w, o_sign_w); end
    n_cmp++; if (o_dbg !== 32'd0) begin n_fail++; $display("FAIL and_r0_reg: got %h expected 0", o_dbg); end
    run_cmd(5'd0, 5'd11, 5'd9, 5'd10, 0, 0, 5'd0, 32'd0, 0);
    n_cmp++; if (o_wbv_w !== 1'b0 || o_op_e !== 5'd0 || o_busy_w !== 1'b1 || o_dbg !== 32'd0) begin n_fail++; $display("FAIL nop: got valid %b op %h busy %b r11 %h expected 0 00 1 0", o_wbv_w, o_op_e, o_busy_w, o_dbg); end
    run_cmd(5'h1F, 5'd11, 5'd9, 5'd10, 0, 0, 5'd0, 32'd0, 0);
    n_cmp++; if (o_wbv_w !== 1'b0 || o_op_e !== 5'd0 || o_dbg !== 32'd0) begin n_fail++; $display("FAIL op1f: got valid %b op %h r11 %h expected 0 00 0", o_wbv_w, o_op_e, o_dbg); end
    for (int i = 0; i < 32; i++) begin
      dbg_addr = i[4:0]; #1;
      n_cmp++; if (dbg_data !== model[i]) begin n_fail++; $display("FAIL protect_reg%0d: got %h expected %h", i, dbg_data, model[i]); end
    end
    @(negedge clk);
  endtask

  task automatic test_init_collision();
    // R1 holds 7fffffff from the ADD scenario; init R1=5 in the accept cycle
    // and try a preload of R13 during EXEC/WB that must be ignored.
    run_cmd(5'd4, 5'd12, 5'd1, 5'd2, 0, 1, 5'd1, 32'd5, 1);
    n_cmp++; if (o_a_e !== 32'h7FFF_FFFF || o_data_w !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL collide_operand: got a %h data %h expected 7fffffff 7fffffff", o_a_e, o_data_w); end
    for (int i = 0; i < 32; i++) begin
      dbg_addr = i[4:0]; #1;
      n_cmp++; if (dbg_data !== model[i]) begin n_fail++; $display("FAIL collide_reg%0d: got %h expected %h", i, dbg_data, model[i]); end
    end
    n_cmp++; if (model[1] !== 32'd5) begin n_fail++; $display("FAIL collide_r1_model: got %h expected 5", model[1]); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [4:0] op, rd, rs, rt, ia;
    bit hold, ien, eien;
    for (int i = 0; i < 6; i++) init_write(5'($urandom_range(1, 31)), $urandom);
    for (int n = 0; n < 60; n++) begin
      op = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 6));
      rd = 5'($urandom); rs = 5'($urandom); rt = 5'($urandom);
      hold = 1'($urandom); ien = ($urandom_range(0, 3) == 0); eien = 1'($urandom);
      ia = 5'($urandom);
      run_cmd(op, rd, rs, rt, hold, ien, ia, $urandom, eien);
      n_cmp++; if (o_op_e !== x_op || o_a_e !== x_a || o_b_e !== x_b) begin n_fail++; $display("FAIL rnd%0d_launch: got op %h a %h b %h expected %h %h %h", n, o_op_e, o_a_e, o_b_e, x_op, x_a, x_b); end
      n_cmp++; if ({o_rdy0, o_wbv_e, o_wbv_w, o_wbv_i, o_rdy_i} !== {1'b1, 1'b0, x_valid, 1'b0, 1'b1}) begin n_fail++; $display("FAIL rnd%0d_ctrl: got rdy %b wbv %b%b%b rdy_i %b expected valid %b", n, o_rdy0, o_wbv_e, o_wbv_w, o_wbv_i, o_rdy_i, x_valid); end
      if (x_valid) begin
        n_cmp++; if (o_data_w !== x_data || o_sign_w !== x_sign || o_rd_w !== rd) begin n_fail++; $display("FAIL rnd%0d_wb: got data %h sign %b rd %0d expected %h %b %0d", n, o_data_w, o_sign_w, o_rd_w, x_data, x_sign, rd); end
      end
      n_cmp++; if (o_dbg !== model[rd]) begin n_fail++; $display("FAIL rnd%0d_reg: got %h expected %h", n, o_dbg, model[rd]); end
    end
    for (int i = 0; i < 32; i++) begin
      dbg_addr = i[4:0]; #1;
      n_cmp++; if (dbg_data !== model[i]) begin n_fail++; $display("FAIL rnd_final_reg%0d: got %h expected %h", i, dbg_data, model[i]); end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    init_write(5'd1, 32'd3);
    init_write(5'd2, 32'd4);
    cmd_valid = 1; cmd_op = 5'd1; cmd_rd = 5'd8; cmd_rs = 5'd1; cmd_rt = 5'd2;
    @(posedge clk); @(negedge clk);
    cmd_valid = 0;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_exec: got busy %b expected 1", busy); end
    rst = 1; #1;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    n_cmp++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || wb_valid !== 1'b0 || alu_op !== 5'd0) begin n_fail++; $display("FAIL mid_reset: got rdy %b busy %b wbv %b op %h expected 1 0 0 00", cmd_ready, busy, wb_valid, alu_op); end
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (wb_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_after%0d: got wbv %b rdy %b expected 0 1", i, wb_valid, cmd_ready); end
    end
    dbg_addr = 5'd8; #1;
    n_cmp++; if (dbg_data !== model[8]) begin n_fail++; $display("FAIL mid_r8: got %h expected %h", dbg_data, model[8]); end
    dbg_addr = 5'd1; #1;
    n_cmp++; if (dbg_data !== model[1]) begin n_fail++; $display("FAIL mid_r1: got %h expected %h", dbg_data, model[1]); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_back_to_back();
    test_write_protect();
    test_init_collision();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
